// File: rtl/cram_pkg.sv
// Shared types and helpers for the asynchronous cellular-RAM controller.
package cram_pkg;

    localparam int CRAM_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ACCESS,
        RECOVER
    } cram_phase_t;

    // addr carries one spare MSB used as the die select on two-die builds
    typedef struct packed {
        logic                   write;
        logic                   cfg;
        logic [CRAM_ADDR_W:0]   addr;
        logic [15:0]            wdata;
        logic [1:0]             be;
    } cram_req_t;

    typedef struct packed {
        logic        ce0_n;
        logic        ce1_n;
        logic        adv_n;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
        logic        cre;
        logic        dq_oe;
        logic [5:0]  a;
        logic [15:0] dq_out;
    } cram_pins_t;

    localparam cram_pins_t PINS_IDLE = '{
        ce0_n: 1'b1, ce1_n: 1'b1, adv_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
        ub_n: 1'b1, lb_n: 1'b1, cre: 1'b0, dq_oe: 1'b0, a: 6'h00, dq_out: 16'h0000
    };

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cram_async_ctrl_phase_timer.sv
// Loadable down-counter that times each controller phase; done when the count reaches zero.
module cram_phase_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/cram_async_ctrl.sv
// Asynchronous-mode CRAM controller: turns a valid/ready word request into
// ADV-latched read, write and CRE pin sequences for one or two dies.
module cram_async_ctrl
    import cram_pkg::*;
#(
    parameter int NUM_CHIPS       = 2,
    parameter int ADV_CYCLES      = 2,
    parameter int READ_CYCLES     = 6,
    parameter int WRITE_CYCLES    = 6,
    parameter int RECOVERY_CYCLES = 2,
    localparam int AW = CRAM_ADDR_W + $clog2(NUM_CHIPS)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_write,
    input  logic          i_req_cfg,
    input  logic [AW-1:0] i_req_addr,
    input  logic [15:0]   i_req_wdata,
    input  logic [1:0]    i_req_be,
    output logic          o_rsp_valid,
    output logic [15:0]   o_rsp_rdata,
    output logic [15:0]   o_dq_out,
    output logic          o_dq_oe,
    input  logic [15:0]   i_dq_in,
    output logic [5:0]    o_cram_a,
    output logic          o_cram_clk,
    output logic          o_cram_adv_n,
    output logic          o_cram_cre,
    output logic          o_cram_ce0_n,
    output logic          o_cram_ce1_n,
    output logic          o_cram_oe_n,
    output logic          o_cram_we_n,
    output logic          o_cram_ub_n,
    output logic          o_cram_lb_n
);

    localparam int CW = cnt_width(ADV_CYCLES, READ_CYCLES, WRITE_CYCLES, RECOVERY_CYCLES);
    localparam logic [CW-1:0] ADV_LD = CW'(ADV_CYCLES - 1);
    localparam logic [CW-1:0] RD_LD  = CW'(READ_CYCLES - 1);
    localparam logic [CW-1:0] WR_LD  = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] REC_LD = CW'(RECOVERY_CYCLES - 1);

    cram_phase_t   r_state;
    cram_phase_t   w_state_next;
    cram_req_t     r_req;
    cram_req_t     w_req_in;
    cram_req_t     w_req;
    cram_pins_t    r_pins;
    cram_pins_t    w_pins_next;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_rdata;
    logic          w_accept;
    logic          w_done;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_cs1;
    logic          w_access_done;

    cram_phase_timer #(.W(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    assign w_accept      = i_req_valid && (r_state == IDLE);
    assign w_access_done = (r_state == ACCESS) && w_done;

    always_comb begin
        w_req_in       = '0;
        w_req_in.write = i_req_write;
        w_req_in.cfg   = i_req_cfg;
        w_req_in.addr  = (CRAM_ADDR_W + 1)'(i_req_addr);
        w_req_in.wdata = i_req_wdata;
        w_req_in.be    = i_req_be;
        w_req          = w_accept ? w_req_in : r_req;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ADDR;
                    w_load       = 1'b1;
                    w_load_val   = ADV_LD;
                end
            end
            ADDR: begin
                if (w_done) begin
                    w_state_next = ACCESS;
                    w_load       = 1'b1;
                    w_load_val   = r_req.write ? WR_LD : RD_LD;
                end
            end
            ACCESS: begin
                if (w_done) begin
                    w_state_next = RECOVER;
                    w_load       = 1'b1;
                    w_load_val   = REC_LD;
                end
            end
            RECOVER: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Pins are computed from the upcoming phase and registered so they change cleanly on the edge
    always_comb begin
        w_cs1       = (NUM_CHIPS == 2) && w_req.addr[CRAM_ADDR_W];
        w_pins_next = PINS_IDLE;
        if (w_state_next == ADDR || w_state_next == ACCESS) begin
            if (w_cs1) begin
                w_pins_next.ce1_n = 1'b0;
            end else begin
                w_pins_next.ce0_n = 1'b0;
            end
            w_pins_next.cre = w_req.cfg;
            w_pins_next.a   = w_req.addr[21:16];
            {w_pins_next.ub_n, w_pins_next.lb_n} = w_req.write ? ~w_req.be : 2'b00;
            if (w_state_next == ADDR) begin
                w_pins_next.adv_n  = 1'b0;
                w_pins_next.dq_oe  = 1'b1;
                w_pins_next.dq_out = w_req.addr[15:0];
            end else if (w_req.write) begin
                w_pins_next.we_n   = 1'b0;
                w_pins_next.dq_oe  = 1'b1;
                w_pins_next.dq_out = w_req.wdata;
            end else begin
                w_pins_next.oe_n = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_pins      <= PINS_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pins      <= w_pins_next;
            r_rsp_valid <= w_access_done;
            if (w_accept) begin
                r_req <= w_req_in;
            end
            if (w_access_done && !r_req.write) begin
                r_rsp_rdata <= i_dq_in;
            end
        end
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_rdata  = r_rsp_rdata;
    assign o_dq_out     = r_pins.dq_out;
    assign o_dq_oe      = r_pins.dq_oe;
    assign o_cram_a     = r_pins.a;
    assign o_cram_clk   = 1'b0;
    assign o_cram_adv_n = r_pins.adv_n;
    assign o_cram_cre   = r_pins.cre;
    assign o_cram_ce0_n = r_pins.ce0_n;
    assign o_cram_ce1_n = r_pins.ce1_n;
    assign o_cram_oe_n  = r_pins.oe_n;
    assign o_cram_we_n  = r_pins.we_n;
    assign o_cram_ub_n  = r_pins.ub_n;
    assign o_cram_lb_n  = r_pins.lb_n;

endmodule

// File: doc/cram_async_ctrl.md
Name: cram_async_ctrl

Overview:
Parametrised controller for the Pocket's address/data-multiplexed cellular RAM (CRAM) in asynchronous mode. Converts a valid/ready word request stream into ADV-latched read, write and configuration-register (CRE) pin sequences for one or two CRAM dies, with per-phase timing counts. Sits between core logic and the top-level tristate/pin connection. Drives the dq bus as separate out, out-enable and in signals, never as an inout.

Parameters:
NUM_CHIPS, 2, number of dies (1 or 2); 2 adds one chip-select address bit
ADV_CYCLES, 2, clocks the address phase is held with adv_n low (>=1)
READ_CYCLES, 6, clocks oe_n is held low before read data is sampled (>=1)
WRITE_CYCLES, 6, clocks we_n is held low (>=1)
RECOVERY_CYCLES, 2, idle clocks with ce deasserted between transactions (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1=write, 0=read
req_cfg  in  1  drive cre=1 for the whole transaction (BCR/RCR access)
req_addr  in  22+$clog2(NUM_CHIPS)  word address; MSB selects die when NUM_CHIPS=2
req_wdata  in  16  write data
req_be  in  2  byte enables [1]=upper, [0]=lower (writes only)
rsp_valid  out  1  one-cycle pulse: read data valid / write complete
rsp_rdata  out  16  captured read data, held until next read completes
dq_out  out  16  value driven onto dq
dq_oe  out  1  1=drive dq, 0=tristate
dq_in  in  16  sampled dq
cram_a  out  6  address bits 21:16
cram_clk  out  1  held 0 (async mode)
cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n  out  1 each  CRAM pins

Behaviour:
- Reset (asynchronous, any state): state IDLE. Outputs: ce0_n=ce1_n=1, oe_n=1, we_n=1, adv_n=1, ub_n=lb_n=1, cre=0, cram_a=0, cram_clk=0, dq_oe=0, dq_out=0, rsp_valid=0, rsp_rdata=0. Phase counter 0.
- req_ready=1 only in IDLE. Accept on a clock edge with req_valid&req_ready. Request fields are registered at accept and held stable for the whole transaction.
- ADDR (ADV_CYCLES clocks):
  - selected ce_n=0, adv_n=0
  - dq_oe=1, dq_out=addr[15:0], cram_a=addr[21:16], cre=req_cfg
  - oe_n=we_n=1; ub_n/lb_n=0 for reads, ~req_be for writes
- ACCESS (READ_CYCLES or WRITE_CYCLES clocks):
  - adv_n=1, ce_n, cre and cram_a held
  - Read: oe_n=0, dq_oe=0. dq_in is sampled into rsp_rdata on the edge that ends the last ACCESS clock.
  - Write: we_n=0, dq_oe=1, dq_out=wdata.
- RECOVER (RECOVERY_CYCLES clocks): all pins return to the reset/idle values except rsp_rdata. rsp_valid=1 only in the first RECOVER clock. The next edge after RECOVER enters IDLE.
- Timing: with accept at edge E0, rsp_valid is high in the cycle after edge E0+ADV+ACCESS.
  - Minimum request period is 1+ADV+ACCESS+RECOVERY clocks.
  - Defaults: read/write period is 11 clocks; rsp_valid follows 8 edges after accept.
- Chip select: ce1_n is low only when NUM_CHIPS=2 and addr MSB=1; otherwise ce0_n is low. With NUM_CHIPS=1, ce1_n is constant 1.
- Write cycles with req_be=2'b00 still run the full sequence with ub_n=lb_n=1. No bytes are written, and rsp_valid still pulses.
- Single phase counter, width $clog2(max timing parameter + 1). It loads param-1 on phase entry and decrements to 0.
- No overlap: we_n and oe_n are never both 0; dq_oe is never 1 while oe_n=0.
- req_valid while busy is ignored (not queued).
- Reset asserted mid-transaction aborts immediately to idle pins. No rsp_valid is produced for the aborted request.

Decomposition:
- Package cram_pkg:
  - enum cram_phase_t {IDLE, ADDR, ACCESS, RECOVER}
  - struct cram_req_t {write, cfg, addr, wdata, be}
  - constant CRAM_ADDR_W=22
  - localparam function for counter width
- One sub-module, cram_phase_timer: loadable down-counter with done flag. The FSM and pin registers stay in cram_async_ctrl.

Test Plan:
- Read at defaults, addr=22'h12_3456, die 0, dq_in=16'hBEEF during ACCESS:
  - ADDR clocks 1-2: ce0_n=0, adv_n=0, dq_out=16'h3456, cram_a=6'h12
  - ACCESS clocks 3-8: oe_n=0, dq_oe=0
  - clock 9: rsp_valid=1, rsp_rdata=16'hBEEF
  - req_ready returns at clock 11
- Write wdata=16'hA55A, be=2'b10, die-select bit=1:
  - ce1_n=0, ce0_n=1
  - ub_n=0, lb_n=1 through ADDR and ACCESS
  - we_n=0 for exactly 6 clocks with dq_out=16'hA55A
  - rsp_valid pulses once
- Config write, req_cfg=1, addr=22'h08_1D1F: cre=1 and cram_a=6'h08 for all 8 active clocks; cre=0 in RECOVER.
- req_valid held high with 3 reads queued back-to-back: accepts are exactly 11 clocks apart; 3 rsp_valid pulses; the idle cycle has all ce_n=1.
- reset_n low in clock 5 of a write: all pins return to idle values asynchronously; no rsp_valid; next accepted read behaves as in test 1.
- NUM_CHIPS=1, ADV_CYCLES=1, READ_CYCLES=3, RECOVERY_CYCLES=1: ce1_n constant 1; rsp_valid 4 edges after accept; request period 6 clocks.
